// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram AXI4-Lite reader.
// The CDF build is selected by defining HIST_AXI_READER_CDF_EN.
package hist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int NUM_BINS_DEF = 256;

endpackage

// File: rtl/hist_cdf_acc.sv
// Saturating 32-bit running-sum accumulator for the CDF build.
// Instantiated only when HIST_AXI_READER_CDF_EN is defined.
module hist_cdf_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [31:0] din,
    output logic [31:0] sum
);

    logic [32:0] sum_wide;

    assign sum_wide = {1'b0, sum} + {1'b0, din};

    // Accumulate, clamping at all-ones on carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
        end
    end

endmodule

// File: rtl/hist_axi_reader.sv
// Reads NUM_BINS histogram bins over AXI4-Lite, one read in flight.
// Define HIST_AXI_READER_CDF_EN to stream the saturating running sum.
module hist_axi_reader
    import hist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_BINS  = NUM_BINS_DEF,
    localparam int         IDX_W     = $clog2(NUM_BINS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      m_axi_araddr,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    output logic [IDX_W-1:0] bin_idx,
    output logic [31:0]      bin_data,
    output logic             bin_valid
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             ar_hs;
    logic             r_hs;
    logic             r_ok;
    logic             last;
    logic             acc_clr;
    logic             acc_add;

    assign idx_nxt = idx + IDX_W'(1);
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign r_hs    = m_axi_rready && m_axi_rvalid;
    assign r_ok    = (m_axi_rresp == AXI_RESP_OKAY);
    assign last    = (idx == IDX_W'(NUM_BINS - 1));
    assign busy    = (state != IDLE);
    assign acc_clr = (state == IDLE) && start;
    assign acc_add = (state == R) && r_hs && r_ok;

    // Control FSM: sequences one AR/R pair per bin, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            bin_idx       <= '0;
            bin_valid     <= 1'b0;
        end else begin
            done      <= 1'b0;
            bin_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        err           <= 1'b0;
                        m_axi_araddr  <= BASE_ADDR;
                        m_axi_arvalid <= 1'b1;
                        state         <= AR;
                    end
                end
                AR: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= R;
                    end
                end
                R: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        if (r_ok) begin
                            bin_idx   <= idx;
                            bin_valid <= 1'b1;
                            if (last) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                idx           <= idx_nxt;
                                m_axi_araddr  <= BASE_ADDR + 32'({idx_nxt, 2'b00});
                                m_axi_arvalid <= 1'b1;
                                state         <= AR;
                            end
                        end else begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HIST_AXI_READER_CDF_EN
    hist_cdf_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .add_en (acc_add),
        .din    (m_axi_rdata),
        .sum    (bin_data)
    );
`else
    logic unused_clr;
    assign unused_clr = acc_clr;

    // Raw build: capture each OKAY beat's data alongside bin_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_data <= '0;
        end else if (acc_add) begin
            bin_data <= m_axi_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_hist_axi_reader.sv
// Randomized bench for hist_axi_reader against a behavioural model.
// Expected stream follows HIST_AXI_READER_CDF_EN when it is defined.
module tb_hist_axi_reader;

    localparam int          NB   = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        rready;
    logic [7:0]  bin_idx;
    logic [31:0] bin_data;
    logic        bin_valid;

    hist_axi_reader #(
        .BASE_ADDR (BASE),
        .NUM_BINS  (NB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .bin_idx       (bin_idx),
        .bin_data      (bin_data),
        .bin_valid     (bin_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          rel;
    } beat_t;

    beat_t       obs[$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_rel = 0;
    int          ar_starts = 0;
    int          viol = 0;
    logic        err_at_done = 1'b0;
    logic        prev_arv = 1'b0;
    logic [31:0] vals[NB];
    logic [31:0] expv[NB];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: collects the output stream and protocol events.
    always @(negedge clk) begin
        beat_t b;
        if (bin_valid) begin
            b.idx  = int'(bin_idx);
            b.data = bin_data;
            b.rel  = cyc - start_cyc;
            obs.push_back(b);
        end
        if (done) begin
            done_cnt++;
            done_rel    = cyc - start_cyc;
            err_at_done = err;
        end
        if (arvalid && !prev_arv) ar_starts++;
        if (arvalid && rready) viol++;
        if (rready && !busy) viol++;
        prev_arv = arvalid;
    end

    task automatic build_model(input int mode);
        longint acc;
        acc = 0;
        for (int k = 0; k < NB; k++) begin
            case (mode)
                0:       vals[k] = 32'(k);
                1:       vals[k] = $urandom;
                default: vals[k] = 32'h8000_0000;
            endcase
`ifdef HIST_AXI_READER_CDF_EN
            acc = acc + longint'(vals[k]);
            if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
            expv[k] = acc[31:0];
`else
            expv[k] = vals[k];
`endif
        end
    endtask

    task automatic run(input int mode, input int ar_d, input int r_d,
                       input int err_bin, input int rst_bin, input bit poke);
        int  n;
        int  d;
        int  nexp;
        int  lastb;
        bit  zw;
        build_model(mode);
        zw = (ar_d == 0) && (r_d == 0);
        obs.delete();
        done_cnt  = 0;
        ar_starts = 0;
        viol      = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc - 1;
        check("busy_on_start", busy, 1);
        check("err_cleared", err, 0);
        for (int k = 0; k < NB; k++) begin
            n = 0;
            while (!arvalid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) begin
                check("ar_timeout", 0, 1);
                break;
            end
            check("araddr", araddr, BASE + 32'(4 * k));
            d = (ar_d < 0) ? int'($urandom_range(0, 4)) : ar_d;
            repeat (d) begin
                @(posedge clk); #1;
                check("ar_hold", {arvalid, araddr}, {1'b1, BASE + 32'(4 * k)});
            end
            arready = 1'b1;
            @(posedge clk); #1 arready = 1'b0;
            if (k == rst_bin) begin
                rst_n = 1'b0;
                #1;
                check("rst_outs", {busy, done, err, arvalid, rready, bin_valid,
                                   araddr, bin_idx, bin_data}, 0);
                return;
            end
            check("r_state", {rready, arvalid}, 2'b10);
            d = (r_d < 0) ? int'($urandom_range(0, 6)) : r_d;
            repeat (d) begin
                @(posedge clk); #1;
                check("r_hold", {rready, arvalid}, 2'b10);
            end
            rdata  = vals[k];
            rresp  = (k == err_bin) ? 2'b10 : 2'b00;
            rvalid = 1'b1;
            if (poke && k == 5) start = 1'b1;
            @(posedge clk); #1;
            rvalid = 1'b0;
            rresp  = 2'b00;
            start  = 1'b0;
            if (k == err_bin) break;
        end
        nexp  = (err_bin >= 0) ? err_bin : NB;
        lastb = (err_bin >= 0) ? err_bin : NB - 1;
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            check("start_in_done", {busy, arvalid}, 2'b00);
        end
        n = 0;
        while (done_cnt == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("done_count", done_cnt, 1);
        check("err_at_done", err_at_done, err_bin >= 0);
        check("err_sticky", err, err_bin >= 0);
        check("idle_outs", {busy, arvalid, rready}, 0);
        check("ar_issued", ar_starts, lastb + 1);
        check("protocol", viol, 0);
        check("bin_count", obs.size(), nexp);
        for (int i = 0; i < obs.size() && i < nexp; i++) begin
            check("bin_idx", obs[i].idx, i);
            check("bin_data", obs[i].data, expv[i]);
            if (zw) check("bin_cycle", obs[i].rel, 2 * i + 3);
        end
        if (zw) check("done_cycle", done_rel, 2 * lastb + 3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, err, arvalid, rready, bin_valid,
                             araddr, bin_idx, bin_data}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset", {busy, arvalid, rready, bin_valid}, 0);

        run(0, 0, 0, -1, -1, 1'b1);
        run(1, 3, 5, -1, -1, 1'b0);
        run(0, 0, 0, 10, -1, 1'b0);
        run(2, 0, 0, -1, -1, 1'b0);
        run(1, -1, -1, $urandom_range(20, 200), -1, 1'b0);
        run(1, 0, 0, -1, 40, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("rst_release", {busy, arvalid, err}, 0);
        run(1, -1, -1, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_axi_reader.md
# hist_axi_reader

AXI4-Lite read initiator that fetches a complete histogram, one 32-bit bin per read, from the histogram calculator's AXI4-Lite read slave. Bins come out as an indexed stream for the downstream equalization LUT builder. With the CDF option compiled in, the stream carries the running cumulative sum instead of the raw bin counts. It sits in the processing clock domain, between the histogram register window and the LUT writer.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of bin 0 in the slave window.
- NUM_BINS, 256: number of bins to read; must be a power of two, at least 2. IDX_W = $clog2(NUM_BINS).
- clk  in  1  sole clock; one clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run, whether the run completed or aborted.
- err  out  1  sticky; set on a non-OKAY rresp; cleared when the next start is accepted.
- m_axi_araddr  out  32  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- bin_idx  out  IDX_W  index of the bin on bin_data.
- bin_data  out  32  raw bin count or CDF value.
- bin_valid  out  1  one-cycle qualifier for bin_idx and bin_data.

## Operation
- FSM states: IDLE, AR, R, DONE. Reset state is IDLE.
- IDLE: when start=1, clear idx, err and the accumulator, then go to AR.
- AR:
  - arvalid=1 and araddr = BASE_ADDR + {idx, 2'b00}.
  - araddr is stable and arvalid stays high until arvalid&arready; then go to R.
- R:
  - rready=1 and arvalid=0. Wait for rvalid&rready.
  - rresp == OKAY:
    - Register bin_idx=idx and bin_data (raw rdata, or the CDF value); pulse bin_valid.
    - If idx == NUM_BINS-1, go to DONE; otherwise increment idx and go to AR.
  - rresp != OKAY: set err, assert no bin_valid, go to DONE. The run is aborted and no further AR is issued.
- DONE: done=1 for one cycle, then IDLE.
- Only one read is outstanding at a time. rready is low outside R; arvalid is low outside AR.
- start is ignored while busy, including the DONE cycle.
- Reset value of every output is 0, including araddr and bin_data.
- rst_n asserted mid-transfer clears everything asynchronously. The AXI transfer is dropped; the slave shares the reset.

## Timing
- start is sampled at cycle 0; arvalid is high from cycle 1.
- Zero-wait slave: the AR handshake is in cycle 2k+1 and the R handshake in cycle 2k+2 for bin k, so there are 2 cycles per bin.
- bin_valid for bin k is asserted in the cycle after its R handshake.
- done coincides with the last bin_valid, or with the cycle after the error beat.
- NUM_BINS=256 with a zero-wait slave: done is at cycle 513.

## Configuration
- Macro: HIST_AXI_READER_CDF_EN.
- Defined: a 32-bit accumulator adds each OKAY rdata; bin_data is the post-add sum.
  - The sum saturates at 32'hFFFF_FFFF.
  - The accumulator is cleared when start is accepted.
- Undefined: bin_data = rdata; no accumulator logic is present.

## Structure
- Package hist_pkg holds:
  - the FSM state enum;
  - AXI_RESP_OKAY = 2'b00;
  - the default NUM_BINS = 256.
- Sub-module hist_cdf_acc, instantiated only under HIST_AXI_READER_CDF_EN:
  - inputs: clr, add_en, din[31:0];
  - output: sum[31:0];
  - behaviour: saturating add.

## Test plan
- Zero-wait slave returning rdata=i for bin i, raw build:
  - 256 bin_valid pulses with bin_data=i;
  - araddr sequence 0x000..0x3FC;
  - done at cycle 513 with err=0.
- Same stimulus, CDF build:
  - bin_data for bin k = k(k+1)/2;
  - final value 32640.
- Handshake delays: arready delayed 3 cycles, rvalid delayed 5 cycles on every beat:
  - araddr and arvalid held stable while waiting;
  - rready high only in R;
  - all 256 bins correct.
- rresp=SLVERR (2'b10) on bin 10:
  - bins 0–9 emitted and no bin_valid for bin 10;
  - err=1 and a single done pulse;
  - no further arvalid;
  - the next accepted start clears err.
- CDF build, every bin returns 32'h8000_0000:
  - bin 0 = 32'h8000_0000;
  - bins 1–255 = 32'hFFFF_FFFF.
- start pulsed while busy: ignored.
- rst_n=0 during bin 40: all outputs 0 immediately; after release, start restarts at araddr = BASE_ADDR, idx 0.
